// File: rtl/ring_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement controller.
package ring_meas_pkg;

  localparam int DEF_COUNT_W     = 32;
  localparam int DEF_WIN_W       = 32;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev   <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev;

endmodule

// File: rtl/ring_osc_measure_ctrl.sv
// Sequences a ring-oscillator measurement and counts synchronised chain_out edges over a window.
//   state    | meaning
//   ST_IDLE  | waiting for start_i; result registers hold last value
//   ST_ARM   | ring enabled, synchroniser flushing, edges ignored (SYNC_STAGES+1 cycles)
//   ST_RUN   | ring enabled, edges counted (window cycles)
//   ST_DRAIN | ring disabled, in-flight edges still counted (SYNC_STAGES cycles)
//   ST_DONE  | result published, done_o high for one cycle
module ring_osc_measure_ctrl
  import ring_meas_pkg::*;
#(
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIN_W-1:0]   run_cycles_i,
  input  logic               chain_out_i,
  output logic               run_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               overflow_o
);

  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;
  localparam logic [WIN_W-1:0]   ARM_LAST   = WIN_W'(SYNC_STAGES);
  localparam logic [WIN_W-1:0]   DRAIN_LAST = WIN_W'(SYNC_STAGES - 1);

  meas_state_t        state;
  logic [WIN_W-1:0]   win;
  logic [WIN_W-1:0]   tmr;
  logic [COUNT_W-1:0] live;
  logic [COUNT_W-1:0] live_next;
  logic               sat;
  logic               sat_next;
  logic               rise;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .din (chain_out_i),
    .rise(rise)
  );

  // Saturating edge counter; only RUN and DRAIN accumulate.
  always_comb begin
    live_next = live;
    sat_next  = sat;
    if (rise && (state == ST_RUN || state == ST_DRAIN)) begin
      if (live == COUNT_MAX) sat_next = 1'b1;
      else                   live_next = live + COUNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      win        <= '0;
      tmr        <= '0;
      live       <= '0;
      sat        <= 1'b0;
      run_en_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      live   <= live_next;
      sat    <= sat_next;
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (run_cycles_i == '0) begin
              state      <= ST_DONE;
              done_o     <= 1'b1;
              count_o    <= '0;
              overflow_o <= 1'b0;
            end else begin
              state    <= ST_ARM;
              win      <= run_cycles_i;
              tmr      <= ARM_LAST;
              live     <= '0;
              sat      <= 1'b0;
              run_en_o <= 1'b1;
              busy_o   <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (abort_i) begin
            state    <= ST_IDLE;
            run_en_o <= 1'b0;
            busy_o   <= 1'b0;
          end else if (tmr == '0) begin
            state <= ST_RUN;
            tmr   <= win - WIN_W'(1);
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state    <= ST_IDLE;
            run_en_o <= 1'b0;
            busy_o   <= 1'b0;
          end else if (tmr == '0) begin
            state    <= ST_DRAIN;
            tmr      <= DRAIN_LAST;
            run_en_o <= 1'b0;
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (tmr == '0) begin
            // Publish including any edge landing on this final cycle.
            state      <= ST_DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            count_o    <= live_next;
            overflow_o <= sat_next;
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          run_en_o <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_measure_ctrl.sv
// Scoreboard bench: periodic chain_out patterns with random period/window, model of ideal edge counts.
module tb_ring_osc_measure_ctrl;

  localparam int COUNT_W = 4;
  localparam int WIN_W   = 16;
  localparam int SYNC    = 2;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  typedef struct {
    int cnt;
    int ovf;
  } exp_t;

  logic               clk = 1'b0;
  logic               wb_rst_i = 1'b1;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic [WIN_W-1:0]   run_cycles_i = '0;
  logic               chain_out_i = 1'b0;
  logic               run_en_o;
  logic               busy_o;
  logic               done_o;
  logic [COUNT_W-1:0] count_o;
  logic               overflow_o;

  ring_osc_measure_ctrl #(
    .COUNT_W    (COUNT_W),
    .WIN_W      (WIN_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .run_cycles_i(run_cycles_i),
    .chain_out_i (chain_out_i),
    .run_en_o    (run_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  exp_t last_exp = '{cnt: 0, ovf: 0};
  int   held_cnt = 0;
  int   held_ovf = 0;
  int   period   = 2;
  bit   hold_lvl = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // chain_out: square wave of the given period (toggle every period/2 clocks), or a held level.
  initial begin : chain_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (period == 0) begin
        chain_out_i = hold_lvl;
      end else begin
        ph++;
        if (ph >= period / 2) begin
          chain_out_i = ~chain_out_i;
          ph = 0;
        end
      end
    end
  end

  // Monitor: result published on done_o must match the queue head; otherwise it must hold.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (wb_rst_i) begin
        exp_q.delete();
        held_cnt = 0;
        held_ovf = 0;
      end
      @(negedge clk);
      if (done_o) begin
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("done_count", int'(count_o), e.cnt);
          chk("done_overflow", int'(overflow_o), e.ovf);
          held_cnt = e.cnt;
          held_ovf = e.ovf;
        end
      end else begin
        chk("held_count", int'(count_o), held_cnt);
        chk("held_overflow", int'(overflow_o), held_ovf);
      end
    end
  end

  // k = ideal number of rising edges in the counted window (window + SYNC cycles).
  task automatic run_measure(input int win, input int k);
    exp_t e;
    int   en_cyc, lat, exp_lat, exp_en;
    bit   got;
    e.cnt = (win == 0) ? 0 : ((k > CMAX) ? CMAX : k);
    e.ovf = (win != 0 && k > CMAX) ? 1 : 0;
    exp_q.push_back(e);
    last_exp = e;
    exp_lat = (win == 0) ? 0 : (2 * SYNC + 1 + win);
    exp_en  = (win == 0) ? 0 : (SYNC + 1 + win);
    run_cycles_i = WIN_W'(win);
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    en_cyc = 0;
    lat = -1;
    got = 1'b0;
    for (int i = 0; i < win + 40 && !got; i++) begin
      if (run_en_o) en_cyc++;
      if (done_o) begin
        got = 1'b1;
        lat = i;
      end else begin
        cyc(1);
      end
    end
    chk("done_seen", int'(got), 1);
    chk("done_latency", lat, exp_lat);
    chk("run_en_cycles", en_cyc, exp_en);
    cyc(1);
  endtask

  task automatic set_pattern(input int p, input bit lvl);
    period = p;
    hold_lvl = lvl;
    cyc(12);
  endtask

  initial begin : stimulus
    int p, k, dn;
    #2;
    // Reset with chain_out toggling.
    cyc(3);
    chk("rst_run_en", int'(run_en_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_overflow", int'(overflow_o), 0);
    wb_rst_i = 1'b0;
    cyc(2);

    set_pattern(2, 1'b0);
    run_measure(10, (10 + SYNC) / 2);
    set_pattern(4, 1'b0);
    run_measure(14, (14 + SYNC) / 4);
    set_pattern(0, 1'b1);
    run_measure(14, 0);
    set_pattern(2, 1'b0);
    run_measure(40, (40 + SYNC) / 2);

    // Abort in RUN cycle 5, with an ignored start while busy.
    exp_q.push_back('{cnt: 0, ovf: 0});
    run_cycles_i = 20;
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    cyc(1);
    run_cycles_i = 0;
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    cyc(5);
    abort_i = 1'b1;
    void'(exp_q.pop_back());
    cyc(1);
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_run_en", int'(run_en_o), 0);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_o) dn++;
      cyc(1);
    end
    chk("abort_no_done", dn, 0);
    chk("abort_count_kept", int'(count_o), last_exp.cnt);
    chk("abort_ovf_kept", int'(overflow_o), last_exp.ovf);

    // Random periods and windows chosen so the window is a whole number of periods.
    for (int r = 0; r < 10; r++) begin
      p = 2 * $urandom_range(1, 4);
      k = $urandom_range(2, 24);
      set_pattern(p, 1'b0);
      cyc($urandom_range(0, 3));
      run_measure(k * p - SYNC, k);
    end

    // Zero window.
    set_pattern(2, 1'b0);
    run_measure(10, 6);
    run_measure(0, 0);

    // Reset mid-run.
    run_measure(10, 6);
    run_cycles_i = 30;
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    cyc(8);
    chk("midrun_busy_before", int'(busy_o), 1);
    wb_rst_i = 1'b1;
    cyc(1);
    chk("midrun_run_en", int'(run_en_o), 0);
    chk("midrun_busy", int'(busy_o), 0);
    chk("midrun_count", int'(count_o), 0);
    chk("midrun_overflow", int'(overflow_o), 0);
    wb_rst_i = 1'b0;
    cyc(40);
    chk("post_reset_idle", int'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
